// File: rtl/pq_stim_harness_pkg.sv
// Shared types and LFSR helper for the PIEO stimulus harness.
package pq_stim_harness_pkg;

    typedef enum logic [1:0] {OP_ENQ, OP_DEQ, OP_DEQ_F} op_kind_t;

    typedef enum logic [1:0] {ST_IDLE, ST_ISSUE, ST_WAIT} hs_state_t;

    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    // Right-shifting Galois step.
    function automatic logic [15:0] lfsr_step(input logic [15:0] l);
        lfsr_step = {1'b0, l[15:1]} ^ (l[0] ? LFSR_TAPS : 16'h0000);
    endfunction

endpackage

// File: rtl/pq_stim_harness_if.sv
// Harness <-> PIEO core signal bundle; master is the harness side, slave the core side.
interface pq_stim_harness_if #(
    parameter int ELEM_W    = 32,
    parameter int TIME_W    = 16,
    parameter int ID_W      = 10,
    parameter int SUBLIST_W = 5
);
    logic                 dut_reset_done_in;
    logic                 dut_ready_in;
    logic                 start_out;
    logic                 enqueue_f_out;
    logic                 dequeue_out;
    logic                 dequeue_f_out;
    logic [ELEM_W-1:0]    f_out;
    logic [TIME_W-1:0]    curr_time_out;
    logic [ID_W-1:0]      flow_id_out;
    logic [SUBLIST_W-1:0] sublist_id_out;
    logic                 enq_valid_in;
    logic [SUBLIST_W:0]   enq_sublist_in;
    logic                 deq_valid_in;
    logic [ELEM_W-1:0]    deq_element_in;
    logic [ID_W:0]        moved_id_in;
    logic [SUBLIST_W:0]   moved_sublist_in;

    modport master (
        input  dut_reset_done_in, dut_ready_in,
        input  enq_valid_in, enq_sublist_in, deq_valid_in, deq_element_in,
        input  moved_id_in, moved_sublist_in,
        output start_out, enqueue_f_out, dequeue_out, dequeue_f_out,
        output f_out, curr_time_out, flow_id_out, sublist_id_out
    );

    modport slave (
        output dut_reset_done_in, dut_ready_in,
        output enq_valid_in, enq_sublist_in, deq_valid_in, deq_element_in,
        output moved_id_in, moved_sublist_in,
        input  start_out, enqueue_f_out, dequeue_out, dequeue_f_out,
        input  f_out, curr_time_out, flow_id_out, sublist_id_out
    );
endinterface

// File: rtl/pq_sig_misr.sv
// Folds a wide response word into SIG_W bits and accumulates it; PQ_HARNESS_MISR_EN selects
// a polynomial MISR, otherwise a plain XOR accumulator. Latency: sig 1 cycle, sig_bit 2 cycles.
module pq_sig_misr #(
    parameter int          SIG_W    = 32,
    parameter logic [31:0] SIG_POLY = 32'h04C11DB7,
    parameter int          IN_W     = 57
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic [IN_W-1:0]  din,
    output logic [SIG_W-1:0] sig,
    output logic             sig_bit
);
    localparam int NCHUNK = (IN_W + SIG_W - 1) / SIG_W;

    logic [NCHUNK*SIG_W-1:0] pad;
    logic [SIG_W-1:0]        fold;
    logic [SIG_W-1:0]        sig_next;

    always_comb begin
        pad = '0;
        pad[IN_W-1:0] = din;
        fold = '0;
        for (int i = 0; i < NCHUNK; i++) begin
            fold = fold ^ pad[i*SIG_W +: SIG_W];
        end
    end

`ifdef PQ_HARNESS_MISR_EN
    assign sig_next = {sig[SIG_W-2:0], 1'b0}
                    ^ (sig[SIG_W-1] ? SIG_POLY[SIG_W-1:0] : {SIG_W{1'b0}})
                    ^ fold;
`else
    assign sig_next = sig ^ fold;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            sig     <= '0;
            sig_bit <= 1'b0;
        end else begin
            if (en) begin
                sig <= sig_next;
            end
            sig_bit <= ^sig;
        end
    end

endmodule

// File: rtl/pq_stim_harness.sv
// Self-driving weighted op generator plus response signature for the PIEO core (MISR mode: PQ_HARNESS_MISR_EN).
// Start pulses 1 cycle after ready in ISSUE, then GAP idle cycles; responses fold into sig_out after 1 cycle.
module pq_stim_harness
    import pq_stim_harness_pkg::*;
#(
    parameter int          ELEM_W     = 32,
    parameter int          TIME_W     = 16,
    parameter int          ID_W       = 10,
    parameter int          SUBLIST_W  = 5,
    parameter int          SIG_W      = 32,
    parameter logic [31:0] SIG_POLY   = 32'h04C11DB7,
    parameter logic [15:0] LFSR_SEED  = 16'hACE1,
    parameter int          ENQ_WEIGHT = 8,
    parameter int          GAP        = 2,
    parameter int          CNT_W      = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                run_in,
    pq_stim_harness_if.master   core,
    output logic [SIG_W-1:0]    sig_out,
    output logic                sig_bit_out,
    output logic [CNT_W-1:0]    enq_count_out,
    output logic [CNT_W-1:0]    deq_count_out,
    output logic                busy_out
);
    localparam logic [15:0] SEED   = (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;
    localparam int          GAP_CW = (GAP > 1) ? $clog2(GAP) : 1;
    localparam logic [4:0]  ENQ_W5 = 5'(ENQ_WEIGHT);
    localparam int          IN_W   = 2 * (SUBLIST_W + 1) + ELEM_W + ID_W + 3;

    hs_state_t             state;
    logic [15:0]           lfsr;
    logic [GAP_CW-1:0]     gap_cnt;
    op_kind_t              op_c;
    logic [ELEM_W-1:0]     f_c;
    logic [ID_W-1:0]       flow_c;

    // Operand widths wider than the LFSR simply repeat its bits.
    always_comb begin
        f_c    = '0;
        flow_c = '0;
        for (int i = 0; i < ELEM_W; i++) f_c[i]    = lfsr[i % 16];
        for (int i = 0; i < ID_W; i++)   flow_c[i] = lfsr[i % 16];
        if ({1'b0, lfsr[3:0]} < ENQ_W5) op_c = OP_ENQ;
        else if (lfsr[4])               op_c = OP_DEQ;
        else                            op_c = OP_DEQ_F;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state              <= ST_IDLE;
            lfsr               <= SEED;
            gap_cnt            <= '0;
            core.start_out     <= 1'b0;
            core.enqueue_f_out <= 1'b0;
            core.dequeue_out   <= 1'b0;
            core.dequeue_f_out <= 1'b0;
            core.f_out         <= '0;
            core.flow_id_out   <= '0;
            core.sublist_id_out <= '0;
        end else begin
            core.start_out     <= 1'b0;
            core.enqueue_f_out <= 1'b0;
            core.dequeue_out   <= 1'b0;
            core.dequeue_f_out <= 1'b0;
            core.f_out         <= '0;
            core.flow_id_out   <= '0;
            core.sublist_id_out <= '0;
            case (state)
                ST_IDLE: begin
                    if (core.dut_reset_done_in && run_in) state <= ST_ISSUE;
                end
                ST_ISSUE: begin
                    if (core.dut_ready_in) begin
                        if (run_in) begin
                            core.start_out      <= 1'b1;
                            core.enqueue_f_out  <= (op_c == OP_ENQ);
                            core.dequeue_out    <= (op_c == OP_DEQ);
                            core.dequeue_f_out  <= (op_c == OP_DEQ_F);
                            core.f_out          <= f_c;
                            core.flow_id_out    <= flow_c;
                            core.sublist_id_out <= lfsr[15 -: SUBLIST_W];
                            lfsr                <= lfsr_step(lfsr);
                            gap_cnt             <= '0;
                            state               <= ST_WAIT;
                        end else begin
                            state <= ST_IDLE;
                        end
                    end
                end
                ST_WAIT: begin
                    if (gap_cnt == GAP_CW'(GAP - 1)) state <= ST_ISSUE;
                    else                             gap_cnt <= gap_cnt + GAP_CW'(1);
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign busy_out = (state != ST_IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            core.curr_time_out <= '0;
            enq_count_out      <= '0;
            deq_count_out      <= '0;
        end else begin
            core.curr_time_out <= core.curr_time_out + TIME_W'(1);
            if (core.enq_valid_in && (enq_count_out != {CNT_W{1'b1}}))
                enq_count_out <= enq_count_out + CNT_W'(1);
            if (core.deq_valid_in && (deq_count_out != {CNT_W{1'b1}}))
                deq_count_out <= deq_count_out + CNT_W'(1);
        end
    end

    // enq_valid lands in bit 0 of the folded word, moved_sublist at the top.
    pq_sig_misr #(
        .SIG_W    (SIG_W),
        .SIG_POLY (SIG_POLY),
        .IN_W     (IN_W)
    ) u_sig (
        .clk     (clk),
        .rst     (rst),
        .en      (core.enq_valid_in | core.deq_valid_in),
        .din     ({core.moved_sublist_in, core.moved_id_in, core.deq_element_in,
                   core.deq_valid_in, core.enq_sublist_in, core.enq_valid_in}),
        .sig     (sig_out),
        .sig_bit (sig_bit_out)
    );

endmodule
